// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID instruction queue (circular buffer with flush and stall)
// Optional empty-queue bypass selected by macro IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int ADDR_LEN = 32,
  parameter int INST_LEN = 32,
  parameter int DEPTH    = 4,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                jump_or_not,
  input  logic                if_valid,
  input  logic [ADDR_LEN-1:0] if_pc,
  input  logic [INST_LEN-1:0] if_inst,
  output logic                if_ready,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [ADDR_LEN-1:0] id_pc,
  output logic [INST_LEN-1:0] id_inst,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_LEN-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_LEN-1:0] pc_mem_d   [DEPTH];
  logic [INST_LEN-1:0] inst_mem_q [DEPTH];
  logic [INST_LEN-1:0] inst_mem_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      count_q, count_d;

  logic not_empty;
  logic byp_active;
  logic byp_take;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign if_ready  = (count_q != FULL);
  assign count     = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
  // An empty queue hands the fetched word straight to ID; it is only stored if ID does not take it.
  assign byp_active = !not_empty && if_valid && !jump_or_not;
  assign byp_take   = byp_active && id_ready && rdy;
`else
  assign byp_active = 1'b0;
  assign byp_take   = 1'b0;
`endif

  assign push = rdy && if_valid && if_ready && !jump_or_not && !byp_take;
  assign pop  = rdy && not_empty && id_ready && !jump_or_not;

  always_comb begin
    id_valid = not_empty;
    id_pc    = '0;
    id_inst  = '0;
    if (not_empty) begin
      id_pc   = pc_mem_q[rd_ptr_q];
      id_inst = inst_mem_q[rd_ptr_q];
    end else if (byp_active) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = if_inst;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (rdy) begin
      if (jump_or_not) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          pc_mem_d[wr_ptr_q]   = if_pc;
          inst_mem_d[wr_ptr_q] = if_inst;
          wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; it is only visible through a valid head entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter ADDR_LEN, default 32, SHALL set the PC field width in bits.
REQ-002 Parameter INST_LEN, default 32, SHALL set the instruction field width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the entry count; it is a power of two and at least 2. PTR_W = log2(DEPTH).
REQ-004 clk  input  1  rising-edge clock; the only clock in the block.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rdy  input  1  chip ready; low freezes all state.
REQ-007 jump_or_not  input  1  branch/jump flush request from EX.
REQ-008 if_valid  input  1  IF presents a fetched instruction.
REQ-009 if_pc  input  ADDR_LEN  PC of the offered instruction.
REQ-010 if_inst  input  INST_LEN  offered instruction word.
REQ-011 if_ready  output  1  queue can accept an entry; equals (count != DEPTH).
REQ-012 id_ready  input  1  ID consumes the head entry this cycle.
REQ-013 id_valid  output  1  head entry is valid.
REQ-014 id_pc  output  ADDR_LEN  PC of the head entry; zero when id_valid=0.
REQ-015 id_inst  output  INST_LEN  instruction of the head entry; zero when id_valid=0.
REQ-016 count  output  PTR_W+1  current occupancy, range 0..DEPTH.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH {pc, inst} entries, with rd_ptr and wr_ptr of PTR_W bits and a PTR_W+1-bit occupancy counter.
REQ-018 Push SHALL occur on a clock edge when rdy && if_valid && if_ready && !jump_or_not. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-019 Pop SHALL occur on a clock edge when rdy && id_valid && id_ready && !jump_or_not, and rd_ptr increments modulo DEPTH.
REQ-020 When push and pop coincide, count SHALL stay the same and both pointers SHALL advance. This is legal at any count from 1 to DEPTH-1.
REQ-021 When full (count=DEPTH), if_ready=0. if_valid is then ignored even when a pop occurs in the same cycle, so there is no full-cycle pass-through.
REQ-022 id_valid, id_pc and id_inst SHALL be combinational from the entry at rd_ptr. id_valid = (count != 0).
REQ-023 Push-to-id_valid latency SHALL be 1 cycle when the queue is empty (except as stated in REQ-032).
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-025 Flush: jump_or_not=1 with rdy=1 SHALL, at the edge, set count, rd_ptr and wr_ptr to 0. It discards any concurrent push and pop. Stored payload contents need not be cleared.
REQ-026 rdy=0 SHALL hold pointers, count and storage unchanged, including when jump_or_not=1. Outputs still reflect the held state.
REQ-027 Priority SHALL be rst > (rdy && jump_or_not) > push/pop > hold.

Reset
REQ-028 On rst=1 at a rising edge, count, rd_ptr and wr_ptr SHALL become 0, regardless of rdy.
REQ-029 After reset, id_valid=0, id_pc=0, id_inst=0, if_ready=1 and count=0 SHALL hold from the first post-reset cycle.
REQ-030 Reset asserted mid-operation SHALL discard all entries. A push or pop in the reset cycle has no effect.

Configuration
REQ-031 Macro IF_ID_QUEUE_BYPASS_EN SHALL select the empty-queue bypass feature.
REQ-032 With IF_ID_QUEUE_BYPASS_EN defined, when count=0 and if_valid=1 and jump_or_not=0, the following SHALL hold:
- id_valid=1, id_pc=if_pc and id_inst=if_inst, combinationally.
- If id_ready=1 and rdy=1, the entry is consumed and not stored, so count stays 0.
- Otherwise it is pushed normally.
REQ-033 Without IF_ID_QUEUE_BYPASS_EN, no combinational path from if_* to id_* SHALL exist, and empty-queue latency is 1 cycle.

Verification
REQ-034 Reset then push A(pc=0x100,inst=0x00000013), id_ready=0 -> next cycle id_valid=1, id_pc=0x100, count=1; during reset id_valid=0, if_ready=1.
REQ-035 DEPTH=4: push 0x200,0x204,0x208,0x20C, id_ready=0 -> count=4, if_ready=0; fifth if_valid is ignored; then pop 4 times -> PCs in order 0x200..0x20C, count=0.
REQ-036 Wrap: push/pop continuously for 10 entries, PCs 0x0..0x24 -> output order identical and count constant at 1 after the first push.
REQ-037 Count=3, jump_or_not=1 with if_valid=1 and id_ready=1 -> next cycle count=0, id_valid=0, if_ready=1, and the concurrent entry is not stored.
REQ-038 rdy=0 for 3 cycles with if_valid=1, id_ready=1 and jump_or_not=1 -> count, id_pc and id_valid are unchanged throughout.
REQ-039 Empty queue, if_valid=1, pc=0x300, id_ready=1 -> with IF_ID_QUEUE_BYPASS_EN: same-cycle id_valid=1, id_pc=0x300, count stays 0; without it: id_valid=0 that cycle, then id_pc=0x300 next cycle.
